ahb_sramc_slave_if: RTL and testbench

Parametrised AHB-Lite slave front end for the SRAM controller. Decodes a byte-addressed AHB transfer onto `NUM_BANKS` banks of `DATA_WIDTH/8` byte-wide SRAMs. Inserts wait states for synchronous SRAM read latency and returns a two-cycle ERROR response for out-of-range or misaligned transfers. Sits between the AHB interconnect and the SRAM bank array, with the memory macros directly below it.

---
 rtl/sramc_pkg.sv | 40 ++++
 rtl/sramc_lane_dec.sv | 59 +++++
 rtl/ahb_sramc_slave_if.sv | 147 ++++++++++++++
 tb/tb_ahb_sramc_slave_if.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sramc_pkg.sv
// Shared types and helpers for the AHB SRAM controller slave front end.
package sramc_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_DONE,
    S_ERR1,
    S_ERR2
  } slv_state_t;

  localparam hresp_t HRESP_OKAY  = RESP_OKAY;
  localparam hresp_t HRESP_ERROR = RESP_ERROR;

  // 2**size contiguous ones starting at offset, clipped to the bus width
  function automatic logic [7:0] lane_mask(
    input logic [2:0] size,
    input logic [2:0] offset,
    input int         bytes
  );
    logic [15:0] m;
    m = (16'd1 << (16'd1 << size)) - 16'd1;
    m = m << offset;
    m = m & ((16'd1 << bytes) - 16'd1);
    return m[7:0];
  endfunction

endpackage

// File: rtl/sramc_lane_dec.sv
// Bank/lane chip-select decoder with range and alignment checking.
module sramc_lane_dec
  import sramc_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_BANKS       = 2,
  parameter int SRAM_ADDR_WIDTH = 13,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int OFS   = $clog2(BYTES),
  localparam int BK    = $clog2(NUM_BANKS),
  localparam int BKW   = (BK > 0) ? BK : 1
) (
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [2:0]                 size,
  output logic [NUM_BANKS*BYTES-1:0] cs,
  output logic [SRAM_ADDR_WIDTH-1:0] word,
  output logic [BKW-1:0]             bank,
  output logic                       err
);

  localparam int TOP = OFS + SRAM_ADDR_WIDTH + BK;

  logic       oor;
  logic       mis;
  logic [3:0] lo;
  logic [3:0] lowm;
  logic [7:0] lanes;

  generate
    if (TOP < ADDR_WIDTH) begin : g_oor
      assign oor = |addr[ADDR_WIDTH-1:TOP];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
    if (BK > 0) begin : g_bank
      assign bank = addr[OFS+SRAM_ADDR_WIDTH +: BKW];
    end else begin : g_one_bank
      assign bank = '0;
    end
  endgenerate

  assign word  = addr[OFS +: SRAM_ADDR_WIDTH];
  assign lo    = 4'(addr[OFS-1:0]);
  assign lowm  = (4'd1 << size) - 4'd1;
  assign mis   = (int'(size) > OFS) || ((lo & lowm) != 4'd0);
  assign err   = oor | mis;
  assign lanes = lane_mask(size, 3'(addr[OFS-1:0]), BYTES);

  always_comb begin
    cs = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!err && bank == BKW'(b)) begin
        cs[b*BYTES +: BYTES] = lanes[BYTES-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_sramc_slave_if.sv
// AHB-Lite slave front end for a banked, byte-laned synchronous SRAM.
// Define SRAMC_ERR_RESP_EN to answer bad transfers with a 2-cycle ERROR.
module ahb_sramc_slave_if
  import sramc_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_BANKS       = 2,
  parameter int SRAM_ADDR_WIDTH = 13,
  parameter int RD_LATENCY      = 1
) (
  input  logic                            hclk,
  input  logic                            hresetn,
  input  logic                            hsel,
  input  logic [ADDR_WIDTH-1:0]           haddr,
  input  logic [1:0]                      htrans,
  input  logic                            hwrite,
  input  logic [2:0]                      hsize,
  input  logic [2:0]                      hburst,
  input  logic [DATA_WIDTH-1:0]           hwdata,
  input  logic                            hready,
  output logic                            hready_resp,
  output logic [1:0]                      hresp,
  output logic [DATA_WIDTH-1:0]           hrdata,
  output logic [SRAM_ADDR_WIDTH-1:0]      sram_addr,
  output logic [DATA_WIDTH-1:0]           sram_wdata,
  output logic                            sram_we,
  output logic [NUM_BANKS*DATA_WIDTH/8-1:0] bank_cs,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] sram_rdata
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BK    = $clog2(NUM_BANKS);
  localparam int BKW   = (BK > 0) ? BK : 1;
  localparam int NCS   = NUM_BANKS * BYTES;

  htrans_t    trans;
  slv_state_t state;
  slv_state_t nxt;
  slv_state_t start_st;
  hresp_t     resp;

  logic                       acc;
  logic                       rdy;
  logic [2:0]                 cnt;
  logic [NCS-1:0]             dec_cs;
  logic [NCS-1:0]             cs_q;
  logic [SRAM_ADDR_WIDTH-1:0] dec_word;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic [BKW-1:0]             dec_bank;
  logic [BKW-1:0]             bank_q;
  logic                       dec_err;
  logic                       we_q;
  logic [2:0]                 burst_q;
  logic [DATA_WIDTH-1:0]      rd_slice;
  logic [DATA_WIDTH-1:0]      hrdata_q;

  sramc_lane_dec #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .NUM_BANKS      (NUM_BANKS),
    .SRAM_ADDR_WIDTH(SRAM_ADDR_WIDTH)
  ) u_dec (
    .addr(haddr),
    .size(hsize),
    .cs  (dec_cs),
    .word(dec_word),
    .bank(dec_bank),
    .err (dec_err)
  );

  assign trans = htrans_t'(htrans);
  assign rdy   = !(state == S_RD_WAIT || state == S_ERR1);
  assign resp  = (state == S_ERR1 || state == S_ERR2)
               ? HRESP_ERROR : HRESP_OKAY;
  assign acc   = hsel && hready && rdy
               && (trans == HT_NONSEQ || trans == HT_SEQ);

  assign hready_resp = rdy;
  assign hresp       = resp;
  assign sram_addr   = addr_q;
  assign sram_wdata  = hwdata;
  assign sram_we     = we_q;
  assign bank_cs     = cs_q;
  assign rd_slice    = sram_rdata[bank_q*DATA_WIDTH +: DATA_WIDTH];
  assign hrdata      = (state == S_RD_DONE) ? rd_slice : hrdata_q;

  always_comb begin
    start_st = S_IDLE;
    if (acc) begin
      if (dec_err) begin
`ifdef SRAMC_ERR_RESP_EN
        start_st = S_ERR1;
`else
        start_st = S_IDLE;
`endif
      end else if (!hwrite) begin
        start_st = S_RD_WAIT;
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_RD_WAIT: if (cnt == 3'(RD_LATENCY)) nxt = S_RD_DONE;
`ifdef SRAMC_ERR_RESP_EN
      S_ERR1:    nxt = S_ERR2;
      S_ERR2:    nxt = start_st;
`endif
      default:   nxt = start_st;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      cnt      <= 3'd1;
      cs_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      bank_q   <= '0;
      burst_q  <= '0;
      hrdata_q <= '0;
    end else begin
      state <= nxt;
      cnt   <= (state == S_RD_WAIT) ? cnt + 3'd1 : 3'd1;
      cs_q  <= '0;
      we_q  <= 1'b0;
      if (state == S_RD_DONE) hrdata_q <= rd_slice;
      if (acc) begin
        addr_q  <= dec_word;
        bank_q  <= dec_bank;
        burst_q <= hburst;
        if (!dec_err) begin
          cs_q <= dec_cs;
          we_q <= hwrite;
        end
`ifndef SRAMC_ERR_RESP_EN
        // bad reads still complete, returning zero data
        else if (!hwrite) hrdata_q <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ahb_sramc_slave_if.sv
// Scoreboard bench for ahb_sramc_slave_if with a 2-bank byte-laned SRAM model.
module tb_ahb_sramc_slave_if;

  localparam int LAT = 2;

  typedef struct {
    logic        rd;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  logic        clk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_we;
  logic [7:0]  bank_cs;
  logic [63:0] sram_rdata;

  logic [31:0] mem [2][8192];
  logic [31:0] p0 [2];
  logic [31:0] p1 [2];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  assign hready     = hready_resp;
  assign sram_rdata = {p1[1], p1[0]};

  ahb_sramc_slave_if #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .NUM_BANKS      (2),
    .SRAM_ADDR_WIDTH(13),
    .RD_LATENCY     (LAT)
  ) dut (
    .hclk       (clk),
    .hresetn    (hresetn),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hburst     (hburst),
    .hwdata     (hwdata),
    .hready     (hready),
    .hready_resp(hready_resp),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we    (sram_we),
    .bank_cs    (bank_cs),
    .sram_rdata (sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // SRAM model: byte-lane writes, RD_LATENCY=2 read pipeline
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 4; j++) begin
        if (bank_cs[b*4+j] && sram_we)
          mem[b][sram_addr][j*8 +: 8] <= sram_wdata[j*8 +: 8];
      end
      p0[b] <= (|bank_cs[b*4 +: 4] && !sram_we) ? mem[b][sram_addr] : 32'h0;
      p1[b] <= p0[b];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data-phase monitor: pops the scoreboard on each completed transfer
  initial begin
    bit   dph;
    int   waits;
    exp_t e;
    dph = 0;
    waits = 0;
    forever begin
      @(negedge clk);
      if (!hresetn) begin
        dph = 0;
      end else begin
        if (dph) begin
          if (exp_q.size() == 0) begin
            chk("sb_empty", 64'(exp_q.size()), 64'd1);
            dph = 0;
          end else if (hready_resp) begin
            e = exp_q.pop_front();
            chk("resp", 64'(hresp), 64'(e.resp));
            chk("waits", 64'(waits), 64'(e.waits));
            if (e.rd) chk("rdata", 64'(hrdata), 64'(e.rdata));
            dph = 0;
          end else begin
            waits++;
            chk("wait_resp", 64'(hresp), 64'(exp_q[0].resp));
          end
        end
        if (hsel && hready && htrans[1]) begin
          dph = 1;
          waits = 0;
        end
      end
    end
  end

  function automatic exp_t mk_exp(input logic wr, input logic bad,
                                  input logic [31:0] rexp);
    exp_t e;
`ifdef SRAMC_ERR_RESP_EN
    e.rd    = !wr && !bad;
    e.resp  = bad ? 2'b01 : 2'b00;
    e.waits = bad ? 1 : (wr ? 0 : LAT);
`else
    e.rd    = !wr;
    e.resp  = 2'b00;
    e.waits = (bad || wr) ? 0 : LAT;
`endif
    e.rdata = bad ? 32'h0 : rexp;
    return e;
  endfunction

  task automatic drive_ap(input logic [31:0] a, input logic wr,
                          input logic [2:0] sz);
    hsel   = 1'b1;
    haddr  = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic xfer(input logic [31:0] a, input logic wr,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input logic [31:0] rexp, input logic [7:0] cs_exp,
                      input logic [12:0] wa_exp, input logic bad);
    @(posedge clk);
    #1;
    drive_ap(a, wr, sz);
    exp_q.push_back(mk_exp(wr, bad, rexp));
    @(posedge clk);
    #1;
    hwdata = wd;
    bus_idle();
    @(negedge clk);
    chk("cs", 64'(bank_cs), 64'(cs_exp));
    chk("we", 64'(sram_we), 64'(wr && !bad));
    if (cs_exp != 8'h0) chk("sram_addr", 64'(sram_addr), 64'(wa_exp));
    @(negedge clk);
    chk("cs_1cyc", 64'(bank_cs), 64'd0);
    drain("timeout");
  endtask

  initial begin
    int n;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8192; i++) mem[b][i] = 32'h0;
    hresetn = 1'b0;
    hsel    = 1'b0;
    haddr   = '0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    hsize   = 3'd0;
    hburst  = 3'd0;
    hwdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(hready_resp), 64'd1);
    chk("rst_resp", 64'(hresp), 64'd0);
    chk("rst_rdata", 64'(hrdata), 64'd0);
    chk("rst_cs", 64'(bank_cs), 64'd0);
    chk("rst_we", 64'(sram_we), 64'd0);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    @(posedge clk);
    #1 hresetn = 1'b1;

    // writes: word, byte lane 3 of bank 1, word, halfword
    xfer(32'h0000_0004, 1, 3'd2, 32'hDEADBEEF, 0, 8'h0F, 13'd1, 0);
    xfer(32'h0000_8003, 1, 3'd0, 32'hAB00_0000, 0, 8'h80, 13'd0, 0);
    xfer(32'h0000_0010, 1, 3'd2, 32'h1234_5678, 0, 8'h0F, 13'd4, 0);
    // reads with wait states
    xfer(32'h0000_0004, 0, 3'd2, 0, 32'hDEADBEEF, 8'h0F, 13'd1, 0);
    xfer(32'h0000_8003, 0, 3'd0, 0, 32'hAB00_0000, 8'h80, 13'd0, 0);
    xfer(32'h0000_8002, 1, 3'd1, 32'hCAFE_0000, 0, 8'hC0, 13'd0, 0);
    xfer(32'h0000_8000, 0, 3'd2, 0, 32'hCAFE_0000, 8'hF0, 13'd0, 0);
    xfer(32'h0000_0010, 0, 3'd2, 0, 32'h1234_5678, 8'h0F, 13'd4, 0);
    @(negedge clk);
    chk("rdata_hold", 64'(hrdata), 64'h1234_5678);

    // out of range and misaligned
    xfer(32'h0001_0000, 0, 3'd2, 0, 0, 8'h00, 13'd0, 1);
    xfer(32'h0000_0001, 1, 3'd1, 32'h5555_5555, 0, 8'h00, 13'd0, 1);
    xfer(32'h0000_0000, 0, 3'd3, 0, 0, 8'h00, 13'd0, 1);
    xfer(32'h0000_8001, 0, 3'd2, 0, 0, 8'h00, 13'd0, 1);

    // unselected and IDLE: no access, no wait
    @(posedge clk);
    #1;
    drive_ap(32'h0000_0004, 1, 3'd2);
    hsel = 1'b0;
    @(posedge clk);
    #1;
    hsel   = 1'b1;
    htrans = 2'b00;
    @(negedge clk);
    chk("nosel_cs", 64'(bank_cs), 64'd0);
    chk("nosel_rdy", 64'(hready_resp), 64'd1);
    @(posedge clk);
    #1 bus_idle();
    @(negedge clk);
    chk("idle_cs", 64'(bank_cs), 64'd0);
    chk("idle_we", 64'(sram_we), 64'd0);

    // back-to-back: write, write, read, read accepted in RD_DONE
    @(posedge clk);
    #1;
    drive_ap(32'h0000_0020, 1, 3'd2);
    exp_q.push_back(mk_exp(1, 0, 0));
    @(posedge clk);
    #1;
    hwdata = 32'h1111_2222;
    drive_ap(32'h0000_8020, 1, 3'd2);
    exp_q.push_back(mk_exp(1, 0, 0));
    @(negedge clk);
    chk("b2b_cs0", 64'(bank_cs), 64'h0F);
    chk("b2b_addr0", 64'(sram_addr), 64'd8);
    @(posedge clk);
    #1;
    hwdata = 32'h3333_4444;
    drive_ap(32'h0000_0020, 0, 3'd2);
    exp_q.push_back(mk_exp(0, 0, 32'h1111_2222));
    @(negedge clk);
    chk("b2b_cs1", 64'(bank_cs), 64'hF0);
    chk("b2b_we1", 64'(sram_we), 64'd1);
    @(posedge clk);
    #1;
    drive_ap(32'h0000_8020, 0, 3'd2);
    exp_q.push_back(mk_exp(0, 0, 32'h3333_4444));
    n = 0;
    while (exp_q.size() > 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("b2b_timeout", 64'(exp_q.size()), 64'd1);
    @(posedge clk);
    #1 bus_idle();
    @(negedge clk);
    chk("b2b_cs2", 64'(bank_cs), 64'hF0);
    chk("b2b_rdy2", 64'(hready_resp), 64'd0);
    drain("b2b_drain");

    // reset while a read is waiting
    @(posedge clk);
    #1;
    drive_ap(32'h0000_0004, 0, 3'd2);
    @(posedge clk);
    #1;
    bus_idle();
    hresetn = 1'b0;
    @(negedge clk);
    chk("pre_rst_cs", 64'(bank_cs), 64'h0F);
    chk("pre_rst_rdy", 64'(hready_resp), 64'd0);
    @(negedge clk);
    chk("mid_rst_rdy", 64'(hready_resp), 64'd1);
    chk("mid_rst_cs", 64'(bank_cs), 64'd0);
    chk("mid_rst_resp", 64'(hresp), 64'd0);
    chk("mid_rst_rdata", 64'(hrdata), 64'd0);
    chk("mid_rst_addr", 64'(sram_addr), 64'd0);
    @(posedge clk);
    #1 hresetn = 1'b1;
    xfer(32'h0000_0010, 0, 3'd2, 0, 32'h1234_5678, 8'h0F, 13'd4, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
